config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The block SHALL have parameter CHAIN_LENGTH, default 64, giving the number of configuration bits in the fabric scan chain (legal range 1..4096).
REQ-002 The block SHALL have parameter WORD_WIDTH, default 8, giving the width of incoming configuration words (legal range 8..32).
REQ-003 The block SHALL have port i_Clock, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port i_Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port i_Start, input, 1 bit: a single-cycle request to begin a configuration load.
REQ-006 The block SHALL have port i_WordValid, input, 1 bit: i_Word holds a valid configuration word.
REQ-007 The block SHALL have port i_Word, input, WORD_WIDTH bits: the configuration word, shifted out LSB first.
REQ-008 The block SHALL have port o_WordReady, output, 1 bit: the block accepts i_Word this cycle.
REQ-009 The block SHALL have port o_CfgShiftEn, output, 1 bit: the chain captures o_CfgData on the next rising edge of i_Clock.
REQ-010 The block SHALL have port o_CfgData, output, 1 bit: the serial configuration bit.
REQ-011 The block SHALL have port o_FabricReset, output, 1 bit: holds user logic in reset until configuration is valid.
REQ-012 The block SHALL have ports o_Busy, o_Done and o_Error, outputs, 1 bit each: the status flags.

Function
REQ-013 The block SHALL implement the states IDLE, LOAD, SHIFT, CHECK, DONE and ERROR.
REQ-014 In IDLE, DONE or ERROR, i_Start=1 SHALL clear the bit counter, set o_FabricReset=1 and move to LOAD on the next cycle; i_Start SHALL be ignored in every other state.
REQ-015 In LOAD, o_WordReady SHALL be 1; a cycle with i_WordValid&o_WordReady SHALL latch i_Word into the shift register and move to SHIFT.
REQ-016 In SHIFT, o_CfgShiftEn SHALL be 1 and o_CfgData SHALL equal shift-register bit 0, advancing one bit per cycle, for min(WORD_WIDTH, remaining chain bits) cycles.
REQ-017 Bits of the final word beyond CHAIN_LENGTH SHALL be discarded and SHALL NOT be shifted.
REQ-018 After the last bit of a word, the block SHALL return to LOAD if the bit count is below CHAIN_LENGTH; otherwise it SHALL go to CHECK.
REQ-019 The bit counter SHALL be $clog2(CHAIN_LENGTH+1) bits wide and SHALL never exceed CHAIN_LENGTH.
REQ-020 Without CONFIG_LOADER_CRC_EN, CHECK SHALL last one cycle and then move to DONE.
REQ-021 In DONE, o_Done SHALL be 1 and o_FabricReset SHALL be 0, starting in the first DONE cycle.
REQ-022 o_Busy SHALL be 1 in LOAD, SHIFT and CHECK, and 0 otherwise.
REQ-023 o_CfgShiftEn SHALL be 0 in every state other than SHIFT, and o_WordReady SHALL be 0 in every state other than LOAD.
REQ-024 Stalls on i_WordValid SHALL pause the load indefinitely without corrupting the bit count or the chain contents.

Reset
REQ-025 Assertion of i_Reset SHALL immediately force state IDLE, bit count 0, shift register 0, CRC 0, o_FabricReset=1 and all other outputs 0, including when reset arrives mid-SHIFT.
REQ-026 After reset is released, the block SHALL require i_Start before shifting again; partial chain contents are don't-care.

Configuration
REQ-027 With CONFIG_LOADER_CRC_EN defined, the block SHALL compute a CRC-8 (polynomial 0x07, init 0x00) bit-serially over every bit of every accepted data word, including discarded pad bits.
REQ-028 With CONFIG_LOADER_CRC_EN defined, CHECK SHALL accept one further word via the LOAD handshake, with no shifting, and compare its low 8 bits to the CRC.
REQ-029 With CONFIG_LOADER_CRC_EN defined, a CRC match SHALL move to DONE; a mismatch SHALL move to ERROR with o_Error=1 and o_FabricReset held at 1.
REQ-030 Without CONFIG_LOADER_CRC_EN, there SHALL be no CRC word, no CRC logic, and o_Error SHALL be tied to 0.

Structure
REQ-031 The state enumeration, CRC polynomial and CRC init constants SHALL reside in package config_loader_pkg.
REQ-032 The CRC SHALL be implemented as sub-module config_loader_crc8, instantiated only when CONFIG_LOADER_CRC_EN is defined.

Verification
REQ-033 Basic load: CHAIN_LENGTH=12, WORD_WIDTH=8, i_Start, then words 0xA5, 0x03 -> exactly 12 shift cycles with o_CfgData = 1,0,1,0,0,1,0,1,1,1,0,0, then o_Done=1 and o_FabricReset=0.
REQ-034 Backpressure: the same load with i_WordValid low for 5 cycles between words -> identical bit sequence, no extra o_CfgShiftEn pulses, and o_WordReady high throughout the gap.
REQ-035 Start ignored: i_Start pulsed during SHIFT of the first word -> the load completes unchanged, and o_Done is asserted exactly once.
REQ-036 Reset mid-load: i_Reset asserted at the third bit of the second word -> the next cycle shows IDLE, o_CfgShiftEn=0 and o_FabricReset=1; a following full load succeeds.
REQ-037 CRC path (macro defined): CHAIN_LENGTH=8, word 0x01, CRC word 0x07 -> DONE; CRC word 0x08 -> ERROR with o_Error=1 and o_FabricReset=1; a subsequent i_Start -> LOAD.

Source files
------------

// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration loader: FSM state encoding
// and the CRC-8 (poly 0x07, init 0x00) step used by the optional check.
package config_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/config_loader_crc8.sv
// CRC-8 accumulator: folds one whole configuration word per update, MSB first,
// so the running value matches a standard byte-wise CRC-8 over the word stream.
module config_loader_crc8
  import config_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Clear,
  input  logic                  i_Update,
  input  logic [WORD_WIDTH-1:0] i_Word,
  output logic [7:0]            o_Crc
);

  logic [7:0] crc_q, crc_d, crc_word;

  always_comb begin
    crc_word = crc_q;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      crc_word = crc8_step(crc_word, i_Word[i]);
    end
    crc_d = crc_q;
    if (i_Clear) begin
      crc_d = CRC8_INIT;
    end else if (i_Update) begin
      crc_d = crc_word;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_Crc = crc_q;

endmodule

// File: rtl/config_loader.sv
// Serial fabric configuration loader: accepts words, shifts them LSB first into
// the scan chain. Define CONFIG_LOADER_CRC_EN to append and verify a CRC-8 word.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for i_Start after reset
// ST_LOAD  | o_WordReady high, waiting for the next data word
// ST_SHIFT | shifting the latched word into the chain, one bit per cycle
// ST_CHECK | chain full; CRC word check (one pass-through cycle without CRC)
// ST_DONE  | configuration valid, fabric released from reset
// ST_ERROR | CRC mismatch, fabric held in reset
module config_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LENGTH = 64,
  parameter int unsigned WORD_WIDTH   = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic                  i_WordValid,
  input  logic [WORD_WIDTH-1:0] i_Word,
  output logic                  o_WordReady,
  output logic                  o_CfgShiftEn,
  output logic                  o_CfgData,
  output logic                  o_FabricReset,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Error
);

  localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int WL_W  = $clog2(WORD_WIDTH + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]      remain;
  logic [WL_W-1:0]       word_left_q, word_left_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic                  start_ok;
  logic                  data_accept;

  assign start_ok    = i_Start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
  assign data_accept = i_WordValid && (state_q == ST_LOAD);
  assign remain      = CNT_W'(CHAIN_LENGTH) - bit_cnt_q;

`ifdef CONFIG_LOADER_CRC_EN
  logic [7:0] crc_val;

  config_loader_crc8 #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_crc8 (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (start_ok),
    .i_Update (data_accept),
    .i_Word   (i_Word),
    .o_Crc    (crc_val)
  );
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    word_left_d = word_left_q;
    shreg_d     = shreg_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_ok) begin
          bit_cnt_d = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (data_accept) begin
          shreg_d = i_Word;
          // The final word only shifts the bits the chain still has room for.
          if (32'(remain) < WORD_WIDTH) begin
            word_left_d = WL_W'(remain);
          end else begin
            word_left_d = WL_W'(WORD_WIDTH);
          end
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d     = shreg_q >> 1;
        bit_cnt_d   = bit_cnt_q + 1'b1;
        word_left_d = word_left_q - 1'b1;
        if (word_left_q == WL_W'(1)) begin
          state_d = (bit_cnt_d < CNT_W'(CHAIN_LENGTH)) ? ST_LOAD : ST_CHECK;
        end
      end
      ST_CHECK: begin
`ifdef CONFIG_LOADER_CRC_EN
        if (i_WordValid) begin
          state_d = (i_Word[7:0] == crc_val) ? ST_DONE : ST_ERROR;
        end
`else
        state_d = ST_DONE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      word_left_q <= '0;
      shreg_q     <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      word_left_q <= word_left_d;
      shreg_q     <= shreg_d;
    end
  end

`ifdef CONFIG_LOADER_CRC_EN
  // The trailing CRC word uses the same valid/ready handshake while in CHECK.
  assign o_WordReady = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign o_Error     = (state_q == ST_ERROR);
`else
  assign o_WordReady = (state_q == ST_LOAD);
  assign o_Error     = 1'b0;
`endif

  assign o_CfgShiftEn  = (state_q == ST_SHIFT);
  assign o_CfgData     = o_CfgShiftEn & shreg_q[0];
  assign o_Busy        = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_CHECK);
  assign o_Done        = (state_q == ST_DONE);
  assign o_FabricReset = (state_q != ST_DONE);

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader (CHAIN_LENGTH=12, WORD_WIDTH=8); the CRC
// path is exercised on a second instance when CONFIG_LOADER_CRC_EN is defined.
module tb_config_loader;
  import config_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] word = 8'h00;
  logic       o_WordReady, o_CfgShiftEn, o_CfgData, o_FabricReset, o_Busy, o_Done, o_Error;

  always #5 clk = ~clk;

  config_loader #(.CHAIN_LENGTH(12), .WORD_WIDTH(8)) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Start       (start),
    .i_WordValid   (valid),
    .i_Word        (word),
    .o_WordReady   (o_WordReady),
    .o_CfgShiftEn  (o_CfgShiftEn),
    .o_CfgData     (o_CfgData),
    .o_FabricReset (o_FabricReset),
    .o_Busy        (o_Busy),
    .o_Done        (o_Done),
    .o_Error       (o_Error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Chain-side capture: every bit presented while o_CfgShiftEn is high.
  logic [31:0] bits_q = '0;
  int          nbits = 0;
  int          done_pulses = 0;
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    if (o_CfgShiftEn) begin
      if (nbits < 32) bits_q[nbits] = o_CfgData;
      nbits = nbits + 1;
    end
    if (o_Done && !done_prev) done_pulses = done_pulses + 1;
    done_prev = o_Done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input string tag);
    bit ok;
    ok    = 1'b0;
    valid = 1'b1;
    word  = w;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = o_WordReady;
      tick();
    end
    valid = 1'b0;
    if (!ok) check({tag, "_send_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int i;
    for (i = 0; i < 100 && !o_WordReady; i++) tick();
    if (!o_WordReady) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic full_load(input int gap, input bit start_mid, input string tag);
    int i;
    bits_q = '0;
    nbits = 0;
    done_pulses = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_load"}, o_Busy, 1);
    check({tag, "_ready_load"}, o_WordReady, 1);
    check({tag, "_fabric_rst_load"}, o_FabricReset, 1);
    send(8'hA5, tag);
    if (start_mid) begin
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_ready(tag);
    for (int g = 0; g < gap; g++) begin
      check({tag, "_gap_ready_noshift"}, {o_WordReady, o_CfgShiftEn}, 2'b10);
      tick();
    end
    send(8'h03, tag);
    for (i = 0; i < 50 && !o_Done; i++) tick();
    tick();
    tick();
    tick();
    check({tag, "_nbits"}, nbits, 12);
    check({tag, "_bit_seq"}, bits_q, 32'h0000_03A5);
    check({tag, "_done"}, o_Done, 1);
    check({tag, "_fabric_rst_done"}, o_FabricReset, 0);
    check({tag, "_busy_done"}, o_Busy, 0);
    check({tag, "_done_pulses"}, done_pulses, 1);
  endtask

`ifdef CONFIG_LOADER_CRC_EN
  logic       c_start = 1'b0;
  logic       c_valid = 1'b0;
  logic [7:0] c_word = 8'h00;
  logic       c_ready, c_shift, c_data, c_frst, c_busy, c_done, c_err;

  config_loader #(.CHAIN_LENGTH(8), .WORD_WIDTH(8)) dut_crc (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Start       (c_start),
    .i_WordValid   (c_valid),
    .i_Word        (c_word),
    .o_WordReady   (c_ready),
    .o_CfgShiftEn  (c_shift),
    .o_CfgData     (c_data),
    .o_FabricReset (c_frst),
    .o_Busy        (c_busy),
    .o_Done        (c_done),
    .o_Error       (c_err)
  );

  task automatic csend(input logic [7:0] w);
    bit ok;
    int i;
    for (i = 0; i < 100 && !c_ready; i++) tick();
    ok      = 1'b0;
    c_valid = 1'b1;
    c_word  = w;
    for (i = 0; i < 100 && !ok; i++) begin
      ok = c_ready;
      tick();
    end
    c_valid = 1'b0;
    if (!ok) check("crc_send_timeout", 32'd0, 32'd1);
  endtask

  task automatic crc_run(input logic [7:0] crc_word);
    int i;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    csend(8'h01);
    csend(crc_word);
    for (i = 0; i < 50 && !c_done && !c_err; i++) tick();
  endtask
`endif

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_fabric", o_FabricReset, 1);
    check("rst_outputs", {o_WordReady, o_CfgShiftEn, o_CfgData, o_Busy, o_Done, o_Error}, 6'b0);
    check("rst_state", dut.state_q, ST_IDLE);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_no_start", {o_Busy, o_WordReady}, 2'b00);

    full_load(0, 1'b0, "basic");
    full_load(5, 1'b0, "backpressure");
    full_load(0, 1'b1, "start_ignored");

    // Reset while the third bit of the second word is on the chain.
    bits_q = '0;
    nbits = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    send(8'hA5, "midrst");
    wait_ready("midrst");
    send(8'h03, "midrst");
    tick();
    tick();
    check("midrst_shifting", o_CfgShiftEn, 1);
    rst = 1'b1;
    #1;
    check("midrst_immediate", {o_CfgShiftEn, o_FabricReset, o_Busy}, 3'b010);
    tick();
    check("midrst_state", dut.state_q, ST_IDLE);
    check("midrst_next", {o_CfgShiftEn, o_FabricReset, o_Busy, o_WordReady}, 4'b0100);
    rst = 1'b0;
    nbits = 0;
    tick();
    tick();
    tick();
    check("midrst_needs_start", {o_Busy, o_CfgShiftEn}, 2'b00);
    check("midrst_no_bits", nbits, 0);
    full_load(0, 1'b0, "after_rst");

`ifdef CONFIG_LOADER_CRC_EN
    crc_run(8'h07);
    check("crc_ok_done", c_done, 1);
    check("crc_ok_err", c_err, 0);
    check("crc_ok_fabric", c_frst, 0);
    crc_run(8'h08);
    check("crc_bad_err", c_err, 1);
    check("crc_bad_done", c_done, 0);
    check("crc_bad_fabric", c_frst, 1);
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    check("crc_restart_state", dut_crc.state_q, ST_LOAD);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
